// File: rtl/rx_buf_pkg.sv
// Shared definitions for the Rx packet buffer read side: address widths,
// header field positions, drain FSM state encoding and header helpers.
package rx_buf_pkg;

  localparam int BUF_AW      = 9;
  localparam int BUF_PW      = 10;
  localparam int HDR_LEN_MSB = 63;
  localparam int HDR_LEN_LSB = 32;

  typedef enum logic [7:0] {
    S_IDLE    = 8'h01,
    S_HDR_RD  = 8'h02,
    S_HDR_CHK = 8'h04,
    S_DAT_RD  = 8'h08,
    S_DAT_OUT = 8'h10,
    S_RELEASE = 8'h20
  } rx_state_t;

  // Number of 64-bit data words occupied by a packet of len bytes.
  function automatic logic [15:0] words_of(input logic [31:0] len);
    logic [32:0] sum;
    sum = {1'b0, len} + 33'd7;
    return 16'(sum >> 3);
  endfunction

  // Byte enables for the final word of a packet, LSB-first contiguous.
  function automatic logic [7:0] keep_of(input logic [31:0] len);
    logic [3:0] sh;
    sh = 4'd8 - {1'b0, len[2:0]};
    if (len[2:0] == 3'd0) return 8'hFF;
    return 8'hFF >> sh;
  endfunction

endpackage

// File: rtl/rx_buffer_drain_ctrl_addr_sync.sv
// Two-flop synchronizer for a multi-bit pointer from another clock domain;
// the output only follows once the synchronized value has held for two cycles.
module addr_sync_stable #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync_out
);

  logic [W-1:0] s0;
  logic [W-1:0] s1;
  logic [W-1:0] s1_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0       <= '0;
      s1       <= '0;
      s1_prev  <= '0;
      sync_out <= '0;
    end else begin
      s0      <= async_in;
      s1      <= s0;
      s1_prev <= s1;
      // A pointer caught mid-transition never matches its predecessor.
      if (s1 == s1_prev) sync_out <= s1;
    end
  end

endmodule

// File: rtl/rx_buffer_drain_ctrl.sv
// Read-side drain controller for the Rx packet buffer: walks header/data words
// through the buffer read port, streams them out, then releases buffer space.
module rx_buffer_drain_ctrl
  import rx_buf_pkg::*;
#(
  parameter int RD_LAT      = 2,
  parameter int MAX_BYTES   = 1522,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  commited_wr_address,
  output logic        rd_en,
  output logic [8:0]  rd_addr,
  input  logic [63:0] rd_data,
  output logic        rd_addr_change,
  output logic [9:0]  rd_addr_extended,
  output logic [63:0] out_data,
  output logic [7:0]  out_keep,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] err_count,
  output logic [7:0]  state_dbg
);

  // Stream handshake: a word transfers on a clk edge where out_valid and
  // out_ready are both high; once raised, out_valid and the word fields hold
  // unchanged until that transfer (only reset may drop them earlier).

  rx_state_t         state;
  logic [BUF_PW-1:0] rd_ptr;
  logic [BUF_PW-1:0] ptr_inc;
  logic [BUF_PW-1:0] cwa_sync;
  logic [2:0]        lat_cnt;
  logic [31:0]       len_q;
  logic [15:0]       words_left;
  logic [7:0]        hold_cnt;
  logic [31:0]       hdr_len;
  logic              hdr_bad;
  logic              pending;
  logic              unused_hdr_lo;

  addr_sync_stable #(.W(BUF_PW)) u_cwa_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (commited_wr_address),
    .sync_out (cwa_sync)
  );

  assign ptr_inc       = rd_ptr + 10'd1;
  assign pending       = (rd_ptr != cwa_sync);
  assign hdr_len       = rd_data[HDR_LEN_MSB:HDR_LEN_LSB];
  assign hdr_bad       = (hdr_len == 32'd0) || (hdr_len > 32'(MAX_BYTES));
  assign unused_hdr_lo = ^rd_data[HDR_LEN_LSB-1:0];
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      rd_ptr           <= '0;
      lat_cnt          <= '0;
      len_q            <= '0;
      words_left       <= '0;
      hold_cnt         <= '0;
      rd_en            <= 1'b0;
      rd_addr          <= '0;
      rd_addr_change   <= 1'b0;
      rd_addr_extended <= '0;
      out_data         <= '0;
      out_keep         <= '0;
      out_last         <= 1'b0;
      out_valid        <= 1'b0;
      err_count        <= '0;
    end else begin
      rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pending) begin
            rd_en   <= 1'b1;
            rd_addr <= rd_ptr[BUF_AW-1:0];
            lat_cnt <= '0;
            state   <= S_HDR_RD;
          end
        end
        S_HDR_RD: begin
          if (lat_cnt == 3'(RD_LAT - 1)) state <= S_HDR_CHK;
          else lat_cnt <= lat_cnt + 3'd1;
        end
        S_HDR_CHK: begin
          len_q      <= hdr_len;
          words_left <= words_of(hdr_len);
          if (hdr_bad) begin
            // Corrupt header: drop everything the writer has committed so far.
            rd_ptr           <= cwa_sync;
            rd_addr_extended <= cwa_sync;
            rd_addr_change   <= 1'b1;
            hold_cnt         <= '0;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            state            <= S_RELEASE;
          end else begin
            rd_ptr  <= ptr_inc;
            rd_en   <= 1'b1;
            rd_addr <= ptr_inc[BUF_AW-1:0];
            lat_cnt <= '0;
            state   <= S_DAT_RD;
          end
        end
        S_DAT_RD: begin
          if (lat_cnt == 3'(RD_LAT)) begin
            out_data  <= rd_data;
            out_valid <= 1'b1;
            out_last  <= (words_left == 16'd1);
            out_keep  <= (words_left == 16'd1) ? keep_of(len_q) : 8'hFF;
            state     <= S_DAT_OUT;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        S_DAT_OUT: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            rd_ptr     <= ptr_inc;
            words_left <= words_left - 16'd1;
            if (out_last) begin
              rd_addr_extended <= ptr_inc;
              rd_addr_change   <= 1'b1;
              hold_cnt         <= '0;
              state            <= S_RELEASE;
            end else begin
              rd_en   <= 1'b1;
              rd_addr <= ptr_inc[BUF_AW-1:0];
              lat_cnt <= '0;
              state   <= S_DAT_RD;
            end
          end
        end
        S_RELEASE: begin
          if (hold_cnt == 8'(HOLD_CYCLES - 1)) begin
            rd_addr_change <= 1'b0;
            state          <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_buffer_drain_ctrl.sv
// Bench for rx_buffer_drain_ctrl: a buffer memory model with read latency,
// packet-level expected beat/address queues and release/err_count checks.
module tb_rx_buffer_drain_ctrl;

  localparam int RD_LAT      = 2;
  localparam int MAX_BYTES   = 1522;
  localparam int HOLD_CYCLES = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  commited_wr_address;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [63:0] rd_data;
  logic        rd_addr_change;
  logic [9:0]  rd_addr_extended;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] err_count;
  logic [7:0]  state_dbg;

  int vectors;
  int miscompares;
  int ready_mode;
  int beat_idx;
  int stall_cnt;
  logic [15:0] exp_err;
  logic [72:0] exp_q[$];
  logic [8:0]  exp_addr_q[$];

  always #2 clk = ~clk;

  rx_buffer_drain_ctrl #(
    .RD_LAT(RD_LAT), .MAX_BYTES(MAX_BYTES), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .commited_wr_address(commited_wr_address),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_addr_change(rd_addr_change), .rd_addr_extended(rd_addr_extended),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .err_count(err_count),
    .state_dbg(state_dbg)
  );

  // Buffer model: data for a read appears RD_LAT cycles after rd_en.
  logic [63:0] mem [512];
  logic [63:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= rd_en ? mem[rd_addr] : 64'h0;
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign rd_data = pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream ready: 0 always, 1 random, 2 five-cycle stall on word 3, 3 never.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (out_valid && beat_idx == 2 && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  logic        stalled = 1'b0;
  logic [72:0] stall_word;
  always @(negedge clk) begin
    if (!reset_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_word", {out_last, out_keep, out_data}, stall_word);
      end
      if (rd_en) begin
        chk("rd_en_while_valid", out_valid, 0);
        if (exp_addr_q.size() == 0) chk("rd_en_unexpected", 1, 0);
        else chk("rd_addr", rd_addr, exp_addr_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
        else chk("beat", {out_last, out_keep, out_data}, exp_q.pop_front());
        beat_idx++;
      end
      stalled    = out_valid && !out_ready;
      stall_word = {out_last, out_keep, out_data};
    end
  end

  // Writes one packet at header address h and queues the reads and beats it implies.
  task automatic put_pkt(input logic [9:0] h, input int len, output logic [9:0] nxt);
    int w;
    int r;
    logic [9:0]  a;
    logic [63:0] d;
    logic [7:0]  k;
    mem[h[8:0]] = {32'(len), $urandom};
    exp_addr_q.push_back(h[8:0]);
    nxt = h;
    if (len == 0 || len > MAX_BYTES) return;
    w = (len + 7) / 8;
    r = len % 8;
    for (int i = 0; i < w; i++) begin
      a = h + 10'(i + 1);
      d = {$urandom, $urandom};
      mem[a[8:0]] = d;
      exp_addr_q.push_back(a[8:0]);
      k = (i == w - 1 && r != 0) ? 8'((1 << r) - 1) : 8'hFF;
      exp_q.push_back({(i == w - 1), k, d});
    end
    nxt = h + 10'(w + 1);
  endtask

  task automatic wait_release(input string tag, input logic [9:0] exp_ext);
    int n = 0;
    int hi = 0;
    while (rd_addr_change !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    chk({tag, "_release_seen"}, rd_addr_change, 1);
    while (rd_addr_change === 1'b1 && hi < 16) begin
      chk({tag, "_ext"}, rd_addr_extended, exp_ext);
      hi++;
      @(negedge clk);
    end
    chk({tag, "_hold_cycles"}, hi, HOLD_CYCLES);
    chk({tag, "_ext_held"}, rd_addr_extended, exp_ext);
    chk({tag, "_err_count"}, err_count, exp_err);
  endtask

  task automatic drained(input string tag);
    chk({tag, "_beats_left"}, exp_q.size(), 0);
    chk({tag, "_reads_left"}, exp_addr_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_addr_change"}, rd_addr_change, 0);
    chk({tag, "_addr_ext"}, rd_addr_extended, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_keep"}, out_keep, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  logic [9:0] nxt;
  logic [9:0] ptr;
  logic [9:0] ends [5];

  initial begin
    vectors = 0; miscompares = 0; ready_mode = 0; beat_idx = 0; stall_cnt = 0;
    exp_err = '0;
    commited_wr_address = '0;
    for (int i = 0; i < 512; i++) mem[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    repeat (8) @(negedge clk);

    // len 64 at H=0
    put_pkt(10'd0, 64, nxt);
    commited_wr_address = nxt;
    wait_release("len64", 10'd9);
    drained("len64");

    // len 61 at H=9: last keep 1F
    put_pkt(10'd9, 61, nxt);
    commited_wr_address = nxt;
    wait_release("len61", 10'd18);
    drained("len61");

    // Backpressure on word 3
    ready_mode = 2; beat_idx = 0; stall_cnt = 0;
    put_pkt(10'd18, 48, nxt);
    commited_wr_address = nxt;
    wait_release("bp", 10'd25);
    drained("bp");
    chk("bp_stall_cycles", stall_cnt, 5);
    ready_mode = 0;

    // Corrupt headers flush to the committed pointer
    put_pkt(10'd25, 0, nxt);
    commited_wr_address = 10'd300;
    exp_err = 16'd1;
    wait_release("len0", 10'd300);
    drained("len0");
    put_pkt(10'd300, 4000, nxt);
    commited_wr_address = 10'd1020;
    exp_err = 16'd2;
    wait_release("len4000", 10'd1020);
    drained("len4000");

    // Wrap: H=1020, 5 data words
    put_pkt(10'd1020, 40, nxt);
    commited_wr_address = nxt;
    wait_release("wrap", 10'd2);
    drained("wrap");

    // Length boundaries
    put_pkt(10'd2, 1, nxt);
    commited_wr_address = nxt;
    wait_release("len1", 10'd4);
    ready_mode = 1;
    put_pkt(10'd4, MAX_BYTES, nxt);
    commited_wr_address = nxt;
    wait_release("len_max", 10'd196);
    put_pkt(10'd196, MAX_BYTES + 1, nxt);
    commited_wr_address = 10'd500;
    exp_err = 16'd3;
    wait_release("len_max_plus1", 10'd500);
    drained("bounds");

    // Random batch committed in one step, random backpressure
    ptr = 10'd500;
    for (int i = 0; i < 5; i++) begin
      put_pkt(ptr, int'($urandom_range(1, 600)), nxt);
      ends[i] = nxt;
      ptr = nxt;
    end
    commited_wr_address = ptr;
    for (int i = 0; i < 5; i++) wait_release("rand", ends[i]);
    drained("rand");

    // Reset while a word is waiting in DAT_OUT
    ready_mode = 3;
    put_pkt(ptr, 64, nxt);
    commited_wr_address = nxt;
    begin
      int n = 0;
      while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    end
    chk("rst_reached_dat_out", out_valid, 1);
    #1 reset_n = 1'b0;
    commited_wr_address = '0;
    #1 chk_all_zero("mid_rst");
    exp_q.delete();
    exp_addr_q.delete();
    exp_err = '0;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_change", rd_addr_change, 0);
    chk("post_rst_ext", rd_addr_extended, 0);
    put_pkt(10'd0, 64, nxt);
    commited_wr_address = nxt;
    wait_release("restart", 10'd9);
    drained("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_buffer_drain_ctrl.md
Name: rx_buffer_drain_ctrl

Overview:
- Read-side controller for the 512x64 Rx packet buffer filled by the MAC receive interface (156.25 MHz domain).
- Runs in the 250 MHz domain. Synchronizes the committed write address and walks packets (header word, then data words) through the buffer read port.
- Streams each packet out with valid/ready, then releases buffer space by publishing a new read address with a held change strobe.

Parameters:
- RD_LAT, 2, buffer read latency in clk cycles from rd_en to rd_data valid (1..4).
- MAX_BYTES, 1522, largest legal packet length in bytes; larger lengths are treated as corrupt.
- HOLD_CYCLES, 4, number of cycles rd_addr_change stays high; rd_addr_extended is stable throughout.

Ports:
- clk  in  1  250 MHz clock
- reset_n  in  1  asynchronous, active-low reset
- commited_wr_address  in  10  extended next-header address from the writer (foreign clock domain)
- rd_en  out  1  buffer read strobe
- rd_addr  out  9  buffer read address (rd_ptr[8:0])
- rd_data  in  64  buffer read data, valid RD_LAT cycles after rd_en
- rd_addr_change  out  1  release strobe to the writer
- rd_addr_extended  out  10  released read pointer (first unconsumed header)
- out_data  out  64  packet data word
- out_keep  out  8  byte enables, LSB-first contiguous
- out_last  out  1  final word of packet
- out_valid  out  1  word valid
- out_ready  in  1  downstream accept
- err_count  out  16  corrupt-header events, saturating

Behaviour:
- Reset: all outputs 0; rd_ptr = 0; committed sync registers = 0; state IDLE.
- CDC:
  - commited_wr_address passes through 2 flops (s0, s1).
  - cwa_sync updates from s1 only when s1 == previous s1 (stable for 2 cycles).
- Pending packet: rd_ptr != cwa_sync (10-bit compare; wrap is implicit mod 1024).
- Buffer layout at header address H:
  - Header word holds len = rd_data[63:32]; rd_data[31:0] is ignored.
  - Data occupies H+1 .. H+W, where W = (len+7)>>3.
  - Next header is at H+1+W.
- States:
  - IDLE: if pending -> HDR_RD.
  - HDR_RD: rd_en=1, rd_addr=rd_ptr[8:0]; wait RD_LAT cycles -> HDR_CHK.
  - HDR_CHK (1 cycle): latch len and words_left=W; rd_ptr += 1.
    - If len == 0 or len > MAX_BYTES: rd_ptr <= cwa_sync (flush), err_count++ (saturating at 16'hFFFF) -> RELEASE.
    - Else -> DAT_RD.
  - DAT_RD: rd_en=1 at rd_ptr; wait RD_LAT cycles, then load out_data and assert out_valid -> DAT_OUT.
  - DAT_OUT: hold out_data/keep/last/valid stable until out_ready.
    - On handshake: rd_ptr += 1, words_left -= 1.
    - If out_last -> RELEASE; else -> DAT_RD.
  - RELEASE: rd_addr_extended <= rd_ptr; rd_addr_change = 1 for HOLD_CYCLES cycles; then 0 -> IDLE.
    - rd_addr_extended is held until the next RELEASE.
- Output fields:
  - out_last = (words_left == 1).
  - out_keep = 8'hFF, except on the last word: (len[2:0] == 0) ? 8'hFF : (8'hFF >> (8 - len[2:0])).
- Single outstanding read; throughput is not a requirement.
- rd_en is a 1-cycle pulse per read; no read is issued while out_valid is high.
- rd_ptr wraps 1023 -> 0; rd_addr wraps 511 -> 0 with no special handling.
- A commited_wr_address change mid-packet only affects the next IDLE decision.
- Reset mid-packet: immediate return to reset values. The partially streamed packet is abandoned; no out_last is issued.
- out_valid never deasserts without a handshake, except on reset.

Decomposition:
- Shared package rx_buf_pkg:
  - BUF_AW = 9, BUF_PW = 10
  - HDR_LEN_MSB = 63, HDR_LEN_LSB = 32
  - state encodings (one-hot 8-bit: IDLE, HDR_RD, HDR_CHK, DAT_RD, DAT_OUT, RELEASE)
  - function words_of(len)
  - function keep_of(len)
- Sub-module: addr_sync_stable (2-flop sync plus equal-sample filter, width parameter). It is reusable by the writer for rd_addr_extended.

Test Plan:
- Single packet, len = 64, at H = 0; commited_wr_address = 9; out_ready = 1 -> 8 words out; last out_keep = FF with out_last; then rd_addr_extended = 9 and rd_addr_change high 4 cycles.
- len = 61 -> 8 words; last word out_keep = 8'h1F; next header read at H+9.
- Backpressure: out_ready low 5 cycles on word 3 -> out_data stable; no extra rd_en; order preserved; final pointer correct.
- Wrap: H = 1020, len = 40 (W = 5) -> rd_addr sequence 508, 509, 510, 511, 0, 1; rd_addr_extended = 2 after release.
- Corrupt header len = 0 (then a second case with len = 4000); commited_wr_address = 300 -> no output beat; rd_addr_extended = 300; err_count increments by 1 per case.
- Reset asserted during DAT_OUT -> all outputs 0 immediately. After release: with commited_wr_address = 0, no activity; with commited_wr_address set, restart from H = 0.
